// File: rtl/mdu_pkg.sv
// Shared MDU encodings: request opcodes, datapath select, scheduler states and latencies.
// The MDU datapath uses the same mdu_sel_e constants.
package mdu_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpDiv   = 3'd2,
        OpDivu  = 3'd3,
        OpMfhi  = 3'd4,
        OpMflo  = 3'd5,
        OpMthi  = 3'd6,
        OpMtlo  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        SelMult  = 2'd0,
        SelMultu = 2'd1,
        SelDiv   = 2'd2,
        SelDivu  = 2'd3
    } mdu_sel_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMulRun = 2'd1,
        StDivRun = 2'd2
    } mdu_state_e;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    function automatic logic is_mul_op(logic [2:0] op);
        return (op == OpMult) || (op == OpMultu);
    endfunction

    function automatic logic is_div_op(logic [2:0] op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// 4-bit latency down-counter for the MDU scheduler.
// Priority is clear > load > decrement; it saturates at zero.
module mdu_lat_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       clr_i,
    input  logic       dec_i,
    output logic       zero_o,
    output logic       one_o
);

    logic [3:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);
    assign one_o  = (cnt_q == 4'd1);

endmodule

// File: rtl/mdu_sched.sv
// MDU issue scheduler: accepts MDU-class ops in IDLE, launches mul/div and times completion.
// Define MDU_SCHED_CANCEL_EN to let flush cancel an in-flight multiply/divide (abort pulse).
module mdu_sched
    import mdu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    input  logic [2:0] req_op_i,
    input  logic       flush_i,
    output logic       req_ready_o,
    output logic       stall_o,
    output logic       start_o,
    output logic [1:0] mdu_sel_o,
    output logic       hi_en_o,
    output logic       lo_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       abort_o
);

    mdu_state_e state_q;
    mdu_sel_e   sel_q;

    logic running;
    logic accept;
    logic acc_mul;
    logic acc_div;
    logic cancel;
    logic cnt_zero;
    logic cnt_one;

    assign running     = (state_q != StIdle);
    assign req_ready_o = ~running;
    // Gate on reset so nothing launches while the async reset is held.
    assign accept      = req_valid_i & req_ready_o & ~flush_i & ~rst_i;
    assign acc_mul     = accept & is_mul_op(req_op_i);
    assign acc_div     = accept & is_div_op(req_op_i);

`ifdef MDU_SCHED_CANCEL_EN
    assign cancel = running & flush_i;
`else
    assign cancel = 1'b0;
`endif

    assign stall_o   = req_valid_i & ~req_ready_o & ~flush_i;
    assign start_o   = acc_mul | acc_div;
    assign mdu_sel_o = start_o ? req_op_i[1:0] : sel_q;
    assign hi_en_o   = accept & (req_op_i == OpMthi);
    assign lo_en_o   = accept & (req_op_i == OpMtlo);
    assign busy_o    = running;
    assign done_o    = running & cnt_one & ~cancel;
    assign abort_o   = cancel;

    mdu_lat_counter u_lat_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (start_o),
        .load_val_i (acc_mul ? MUL_LAT : DIV_LAT),
        .clr_i      (cancel),
        .dec_i      (running & ~cnt_zero),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sel_q   <= SelMult;
        end else begin
            if (start_o) begin
                sel_q <= mdu_sel_e'(req_op_i[1:0]);
            end
            unique case (state_q)
                StIdle: begin
                    if (acc_mul) begin
                        state_q <= StMulRun;
                    end else if (acc_div) begin
                        state_q <= StDivRun;
                    end
                end
                StMulRun, StDivRun: begin
                    if (cancel || cnt_one) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mdu_sched.md
MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 SHALL have a single clock, Clk; reset is asynchronous and active-high, Rst.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  asynchronous active-high reset.
REQ-004 req_valid  input  1  decode stage presents an MDU-class instruction.
REQ-005 req_op  input  3  MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7.
REQ-006 flush  input  1  interrupt/exception; squashes the current request.
REQ-007 req_ready  output  1  request accepted this cycle.
REQ-008 stall  output  1  req_valid & ~req_ready & ~flush; freezes the pipeline front end.
REQ-009 start  output  1  one-cycle launch strobe to the MDU datapath.
REQ-010 mdu_sel  output  2  datapath operation select: MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-011 hi_en / lo_en  output  1 each  HI/LO direct-write strobes for MTHI/MTLO.
REQ-012 busy  output  1  multiply/divide in flight.
REQ-013 done  output  1  one-cycle pulse on the cycle HI/LO take the result.
REQ-014 abort  output  1  one-cycle pulse when an in-flight operation is cancelled.

Function
REQ-015 States: IDLE, MUL_RUN, DIV_RUN; every transition on the Clk rising edge.
REQ-016 accept = req_valid & req_ready & ~flush; req_ready = 1 in IDLE; req_ready = 0 in MUL_RUN and DIV_RUN for all ops.
REQ-017 Accept of op 0/1 in IDLE: start=1 and mdu_sel=op combinationally in the accept cycle; 4-bit counter loads MUL_LAT=5; next state MUL_RUN.
REQ-018 Accept of op 2/3: start=1, mdu_sel=op; counter loads DIV_LAT=10; next state DIV_RUN.
REQ-019 Accept of MTHI: hi_en=1 for the accept cycle only. Accept of MTLO: lo_en=1 for the accept cycle only. hi_en and lo_en are never both 1.
REQ-020 Accept of MFHI/MFLO: no output strobe; the op is accepted only in IDLE, so a read never observes a stale HI/LO.
REQ-021 In MUL_RUN/DIV_RUN the counter decrements by 1 per cycle; done=1 while counter==1; on that edge counter becomes 0 and the state returns to IDLE.
REQ-022 busy = (state != IDLE); result latency from start is 5 cycles (multiply) or 10 cycles (divide), matching the datapath.
REQ-023 A request that arrives while busy is held via stall and accepted in the first IDLE cycle, i.e. the cycle after done.
REQ-024 flush with req_valid in the same cycle: flush wins; no accept, start, hi_en or lo_en.
REQ-025 When no accept occurs, mdu_sel holds its last value; start, hi_en, lo_en, done and abort are 0.
REQ-026 The counter never underflows; in IDLE it holds 0.

Reset
REQ-027 Rst asserted: state=IDLE and counter=0 immediately; mdu_sel=0; start, hi_en, lo_en, done, abort, busy and stall=0.
REQ-028 Rst during MUL_RUN/DIV_RUN discards the operation with no done and no abort pulse; req_ready=1 on the first edge after release.

Configuration
REQ-029 Macro MDU_SCHED_CANCEL_EN.
REQ-030 Defined: flush in MUL_RUN/DIV_RUN forces IDLE and counter=0 on the next edge, and abort=1 for that cycle. If flush coincides with counter==1, abort wins and done=0.
REQ-031 Undefined: flush has no effect on an in-flight operation, which completes with done; abort is tied 0.

Structure
REQ-032 Shared package mdu_pkg SHALL hold the req_op and mdu_sel encodings, the state enum, MUL_LAT=5 and DIV_LAT=10; the MDU datapath uses the same mdu_sel constants.
REQ-033 One sub-module, mdu_lat_counter (load value, load strobe, clear, decrement, zero/one flags), instantiated once.

Verification
REQ-034 Reset, then MULT in cycle 0 -> start=1 and mdu_sel=0 in cycle 0; busy in cycles 1-5; done in cycle 5; req_ready=1 in cycle 6.
REQ-035 DIVU accepted, then MFLO presented in the next cycle -> stall=1 for 10 cycles; MFLO accepted in the cycle after done; no second start.
REQ-036 MTHI while idle -> hi_en=1 for exactly 1 cycle, lo_en=0, busy stays 0; back-to-back MTLO the next cycle -> lo_en=1 for 1 cycle.
REQ-037 DIV accepted, flush in the 4th busy cycle -> with MDU_SCHED_CANCEL_EN: abort=1, IDLE on the next edge, no done; without the macro: done still pulses 10 cycles after start.
REQ-038 flush and req_valid(MULTU) in the same idle cycle -> no start, req_ready effect suppressed, state stays IDLE.
REQ-039 Rst asserted mid-MUL_RUN, between clock edges -> busy drops without waiting for an edge; no done or abort pulse; a new MULT after release starts normally.
